bus_resp: RTL and testbench

- Memory-mapped responder at the far end of the CPU address/data bus; the CPU drives addresses and this block answers them.
- Decodes an 8-byte window at parameter BASE and stretches accesses with wait states by pulling RDY low.
- Contains a scratch register and a 16-bit down-counting timer with interrupt.
- Sits beside RAM/ROM on the CPU bus; RDY is wire-ANDed into the core's RDY input.

---
 rtl/bus_resp.sv | 172 +++++++++++++++++
 tb/tb_bus_resp.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_resp.sv
// Memory-mapped bus responder: 8-byte window with wait-state stretching, scratch register and a 16-bit down-counting timer.
// Optional define BUS_RESP_PRESCALE_EN divides the timer tick by PRESCALE.
module bus_resp #(
    parameter logic [15:0] BASE     = 16'hFE00,
    parameter int          WAIT     = 1,
    parameter logic [7:0]  ID       = 8'hA5,
    parameter int          PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        IRQ
);

    localparam bit         W_HAS_WAIT = (WAIT != 0);
    localparam logic [2:0] WAIT_M1    = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    if (WAIT < 0 || WAIT > 7) begin : g_bad_wait
        $error("bus_resp: WAIT must be in 0..7");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("bus_resp: PRESCALE must be in 1..256");
    end

    typedef enum logic {S_IDLE, S_STALL} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_wcnt, w_wcnt_nxt;
    logic        w_hit, w_rdy, w_done;
    logic        w_wr, w_rd, w_lath_wr, w_tick, w_expire;
    logic [2:0]  w_off;
    logic [7:0]  w_rdata;

    logic [7:0]  r_scratch, r_hold, r_di;
    logic        r_en, r_ie, r_ar, r_tf;
    logic [15:0] r_lat, r_tmr;

    assign w_hit = (AB[15:3] == BASE[15:3]);
    assign w_off = AB[2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // w_done marks the cycle whose closing edge commits the access.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_rdy       = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    if (W_HAS_WAIT) begin
                        w_rdy       = 1'b0;
                        w_state_nxt = S_STALL;
                        w_wcnt_nxt  = WAIT_M1;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            S_STALL: begin
                if (r_wcnt == 3'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_rdy      = 1'b0;
                    w_wcnt_nxt = r_wcnt - 3'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign RDY = w_rdy | reset;
    assign DI  = r_di;
    assign IRQ = r_tf & r_ie;

    assign w_wr      = w_done & WE;
    assign w_rd      = w_done & ~WE;
    assign w_lath_wr = w_wr & (w_off == 3'd4);

`ifdef BUS_RESP_PRESCALE_EN
    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);
    logic [7:0] r_pre;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= 8'd0;
        end else if (!r_en || w_lath_wr || r_pre == PRE_MAX) begin
            r_pre <= 8'd0;
        end else begin
            r_pre <= r_pre + 8'd1;
        end
    end

    assign w_tick = r_en & (r_pre == PRE_MAX) & ~w_lath_wr;
`else
    assign w_tick = r_en & ~w_lath_wr;
`endif

    assign w_expire = w_tick & (r_tmr == 16'd0);

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            3'd0: w_rdata = r_scratch;
            3'd1: w_rdata = {5'b0, r_ar, r_ie, r_en};
            3'd2: w_rdata = {7'b0, r_tf};
            3'd3: w_rdata = r_lat[7:0];
            3'd4: w_rdata = r_lat[15:8];
            3'd5: w_rdata = r_tmr[7:0];
            3'd6: w_rdata = r_hold;
            3'd7: w_rdata = ID;
            default: w_rdata = 8'h00;
        endcase
    end

    // Timer update comes first so a same-cycle CTRL write overrides the expiry's EN clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scratch <= 8'h00;
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_ar      <= 1'b0;
            r_tf      <= 1'b0;
            r_lat     <= 16'h0000;
            r_tmr     <= 16'h0000;
            r_hold    <= 8'h00;
            r_di      <= 8'h00;
        end else begin
            if (w_tick) begin
                if (r_tmr != 16'd0) begin
                    r_tmr <= r_tmr - 16'd1;
                end else begin
                    r_tf <= 1'b1;
                    if (r_ar) r_tmr <= r_lat;
                    else      r_en  <= 1'b0;
                end
            end
            if (w_wr) begin
                case (w_off)
                    3'd0: r_scratch <= DO;
                    3'd1: {r_ar, r_ie, r_en} <= DO[2:0];
                    3'd2: if (DO[0] && !w_expire) r_tf <= 1'b0;
                    3'd3: r_lat[7:0] <= DO;
                    3'd4: begin
                        r_lat[15:8] <= DO;
                        r_tmr       <= {DO, r_lat[7:0]};
                    end
                    default: ;
                endcase
            end
            if (w_rd) begin
                r_di <= w_rdata;
                if (w_off == 3'd5) r_hold <= r_tmr[15:8];
            end
        end
    end

endmodule

// File: tb/tb_bus_resp.sv
// Directed bench for bus_resp: one zero-wait instance and one two-wait instance on separate buses.
module tb_bus_resp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ab0 = 16'h0000, ab1 = 16'h0000;
    logic [7:0]  do0 = 8'h00, do1 = 8'h00;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  di0, di1;
    logic        rdy0, rdy1, irq0, irq1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bus_resp #(.BASE(16'hFE00), .WAIT(0), .ID(8'hA5), .PRESCALE(16)) u_dut_w0 (
        .clk(clk), .reset(reset), .AB(ab0), .DO(do0), .WE(we0),
        .DI(di0), .RDY(rdy0), .IRQ(irq0)
    );

    bus_resp #(.BASE(16'hFE00), .WAIT(2), .ID(8'hA5), .PRESCALE(16)) u_dut_w2 (
        .clk(clk), .reset(reset), .AB(ab1), .DO(do1), .WE(we1),
        .DI(di1), .RDY(rdy1), .IRQ(irq1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int d, input logic [15:0] a, input logic w, input logic [7:0] v);
        if (d == 0) begin ab0 = a; we0 = w; do0 = v; end
        else        begin ab1 = a; we1 = w; do1 = v; end
    endtask

    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [7:0] get_di(input int d);
        return (d == 0) ? di0 : di1;
    endfunction

    // Presents one access, counts cycles with RDY low, returns #1 after the completing edge.
    task automatic bus_access(input int d, input logic we_v, input logic [2:0] off,
                              input logic [7:0] wd, output int stalls);
        @(negedge clk);
        drive(d, 16'hFE00 | {13'd0, off}, we_v, wd);
        #1;
        stalls = 0;
        while (!get_rdy(d) && stalls < 16) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 16) begin
            n_total++;
            $display("FAIL bus_timeout dut=%0d: RDY low for %0d cycles, expected RDY=1", d, stalls);
        end
        @(posedge clk);
        #1;
        drive(d, 16'h0000, 1'b0, 8'h00);
    endtask

    task automatic wr(input int d, input logic [2:0] off, input logic [7:0] v);
        int s;
        bus_access(d, 1'b1, off, v, s);
    endtask

    task automatic rd(input int d, input logic [2:0] off, output logic [7:0] v);
        int s;
        bus_access(d, 1'b0, off, 8'h00, s);
        v = get_di(d);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 16'h0000, 1'b0, 8'h00);
        drive(1, 16'h0000, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] v;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (rdy0 !== 1'b1) $display("FAIL reset_rdy0: got %b expected 1", rdy0); else n_pass++;
        n_total++; if (rdy1 !== 1'b1) $display("FAIL reset_rdy1: got %b expected 1", rdy1); else n_pass++;
        n_total++; if (di0 !== 8'h00) $display("FAIL reset_di0: got %h expected 00", di0); else n_pass++;
        n_total++; if (di1 !== 8'h00) $display("FAIL reset_di1: got %h expected 00", di1); else n_pass++;
        n_total++; if (irq0 !== 1'b0) $display("FAIL reset_irq0: got %b expected 0", irq0); else n_pass++;
        n_total++; if (irq1 !== 1'b0) $display("FAIL reset_irq1: got %b expected 0", irq1); else n_pass++;
        reset = 1'b0;
        rd(0, 3'd0, v);
        n_total++; if (v !== 8'h00) $display("FAIL reset_scratch: got %h expected 00", v); else n_pass++;
        rd(0, 3'd1, v);
        n_total++; if (v !== 8'h00) $display("FAIL reset_ctrl: got %h expected 00", v); else n_pass++;
        rd(0, 3'd4, v);
        n_total++; if (v !== 8'h00) $display("FAIL reset_lath: got %h expected 00", v); else n_pass++;
    endtask

    task automatic test_wait_states();
        int s;
        apply_reset();
        bus_access(1, 1'b1, 3'd0, 8'h3C, s);
        n_total++; if (s !== 2) $display("FAIL wait_write_stalls: got %0d expected 2", s); else n_pass++;
        n_total++; if (di1 !== 8'h00) $display("FAIL wait_write_di: got %h expected 00", di1); else n_pass++;
        bus_access(1, 1'b0, 3'd0, 8'h00, s);
        n_total++; if (s !== 2) $display("FAIL wait_read_stalls: got %0d expected 2", s); else n_pass++;
        n_total++; if (di1 !== 8'h3C) $display("FAIL wait_read_di: got %h expected 3c", di1); else n_pass++;
        bus_access(1, 1'b0, 3'd7, 8'h00, s);
        n_total++; if (s !== 2) $display("FAIL wait_id_stalls: got %0d expected 2", s); else n_pass++;
        n_total++; if (di1 !== 8'hA5) $display("FAIL wait_id_di: got %h expected a5", di1); else n_pass++;
    endtask

    task automatic test_zero_wait();
        int s;
        logic [7:0] v;
        apply_reset();
        wr(0, 3'd0, 8'h5A);
        bus_access(0, 1'b0, 3'd7, 8'h00, s);
        n_total++; if (s !== 0) $display("FAIL zw_id_stalls: got %0d expected 0", s); else n_pass++;
        n_total++; if (di0 !== 8'hA5) $display("FAIL zw_id_di: got %h expected a5", di0); else n_pass++;
        @(negedge clk);
        drive(0, 16'h1234, 1'b1, 8'h77);
        #1;
        n_total++; if (rdy0 !== 1'b1) $display("FAIL zw_miss_rdy: got %b expected 1", rdy0); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (di0 !== 8'hA5) $display("FAIL zw_miss_di: got %h expected a5", di0); else n_pass++;
        drive(0, 16'hFE08, 1'b1, 8'h11);
        @(posedge clk);
        #1;
        drive(0, 16'h0000, 1'b0, 8'h00);
        rd(0, 3'd0, v);
        n_total++; if (v !== 8'h5A) $display("FAIL zw_miss_scratch: got %h expected 5a", v); else n_pass++;
        wr(0, 3'd1, 8'hF8);
        rd(0, 3'd1, v);
        n_total++; if (v !== 8'h00) $display("FAIL zw_ctrl_upper: got %h expected 00", v); else n_pass++;
        wr(0, 3'd5, 8'h55);
        rd(0, 3'd5, v);
        n_total++; if (v !== 8'h00) $display("FAIL zw_cntl_ro: got %h expected 00", v); else n_pass++;
    endtask

    task automatic test_one_shot();
        logic [7:0] v;
        apply_reset();
        wr(0, 3'd3, 8'h03);
        wr(0, 3'd4, 8'h00);
        wr(0, 3'd1, 8'h03);
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (irq0 !== 1'b0) $display("FAIL os_irq_early: got %b expected 0", irq0); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (irq0 !== 1'b1) $display("FAIL os_irq_rise: got %b expected 1", irq0); else n_pass++;
        rd(0, 3'd1, v);
        n_total++; if (v !== 8'h02) $display("FAIL os_ctrl_en_off: got %h expected 02", v); else n_pass++;
        rd(0, 3'd2, v);
        n_total++; if (v !== 8'h01) $display("FAIL os_status: got %h expected 01", v); else n_pass++;
        rd(0, 3'd5, v);
        n_total++; if (v !== 8'h00) $display("FAIL os_cnt_stopped: got %h expected 00", v); else n_pass++;
        wr(0, 3'd2, 8'h01);
        n_total++; if (irq0 !== 1'b0) $display("FAIL os_irq_clear: got %b expected 0", irq0); else n_pass++;
    endtask

    task automatic test_auto_reload();
        logic [7:0] v;
        apply_reset();
        wr(0, 3'd3, 8'h02);
        wr(0, 3'd4, 8'h00);
        wr(0, 3'd1, 8'h07);
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (irq0 !== 1'b0) $display("FAIL ar_irq_early: got %b expected 0", irq0); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (irq0 !== 1'b1) $display("FAIL ar_first_expiry: got %b expected 1", irq0); else n_pass++;
        repeat (2) @(posedge clk);
        wr(0, 3'd2, 8'h01);
        n_total++; if (irq0 !== 1'b1) $display("FAIL ar_set_wins: got %b expected 1", irq0); else n_pass++;
        wr(0, 3'd2, 8'h01);
        n_total++; if (irq0 !== 1'b0) $display("FAIL ar_clear: got %b expected 0", irq0); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (irq0 !== 1'b0) $display("FAIL ar_irq_mid: got %b expected 0", irq0); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (irq0 !== 1'b1) $display("FAIL ar_third_expiry: got %b expected 1", irq0); else n_pass++;
        rd(0, 3'd1, v);
        n_total++; if (v !== 8'h07) $display("FAIL ar_ctrl_kept: got %h expected 07", v); else n_pass++;
    endtask

    task automatic test_atomic_read();
        logic [7:0] v;
        apply_reset();
        wr(0, 3'd3, 8'h00);
        wr(0, 3'd4, 8'h01);
        wr(0, 3'd1, 8'h01);
        rd(0, 3'd5, v);
        n_total++; if (v !== 8'h00) $display("FAIL at_cntl: got %h expected 00", v); else n_pass++;
        rd(0, 3'd6, v);
        n_total++; if (v !== 8'h01) $display("FAIL at_cnth_hold: got %h expected 01", v); else n_pass++;
        rd(0, 3'd5, v);
        n_total++; if (v !== 8'hFE) $display("FAIL at_cntl_running: got %h expected fe", v); else n_pass++;
        wr(0, 3'd4, 8'h02);
        rd(0, 3'd5, v);
        n_total++; if (v !== 8'h00) $display("FAIL at_lath_load_lo: got %h expected 00", v); else n_pass++;
        rd(0, 3'd6, v);
        n_total++; if (v !== 8'h02) $display("FAIL at_lath_load_hi: got %h expected 02", v); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        logic [7:0] v;
        apply_reset();
        wr(1, 3'd0, 8'h3C);
        wr(0, 3'd1, 8'h03);
        @(posedge clk);
        #1;
        n_total++; if (irq0 !== 1'b1) $display("FAIL rs_irq_pre: got %b expected 1", irq0); else n_pass++;
        @(negedge clk);
        drive(1, 16'hFE00, 1'b1, 8'hFF);
        #1;
        n_total++; if (rdy1 !== 1'b0) $display("FAIL rs_rdy_low0: got %b expected 0", rdy1); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (rdy1 !== 1'b0) $display("FAIL rs_rdy_low1: got %b expected 0", rdy1); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (rdy1 !== 1'b1) $display("FAIL rs_rdy_immediate: got %b expected 1", rdy1); else n_pass++;
        n_total++; if (irq0 !== 1'b0) $display("FAIL rs_irq_cleared: got %b expected 0", irq0); else n_pass++;
        drive(1, 16'h0000, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        rd(1, 3'd0, v);
        n_total++; if (v !== 8'h00) $display("FAIL rs_scratch: got %h expected 00", v); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_zero_wait();
        test_one_shot();
        test_auto_reload();
        test_atomic_read();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
